// File: rtl/tx_lane_gearbox_if.sv
// Input word handshake for tx_lane_gearbox.
// One transfer carries one wide word for every lane.
interface tx_lane_gearbox_if #(
  parameter int W = 64
);
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/tx_lane_gearbox.sv
// Multi-lane TX gearbox: buffers wide per-lane words in a shared FIFO and slices them into
// SER_W-bit chunks per clk, with PRBS7, clock and idle pattern modes and underflow detection.
`ifndef SERDES_STAGES
`define SERDES_STAGES 2
`endif

module tx_lane_gearbox #(
  parameter int NLANES     = 4,
  parameter int SER_W      = 2**`SERDES_STAGES,
  parameter int RATIO      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstb,
  tx_lane_gearbox_if.slave        in_if,
  input  logic [1:0]              mode,
  input  logic                    msb_first,
  input  logic                    ser_en,
  output logic [NLANES*SER_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    underflow,
  input  logic                    underflow_clr
);
  localparam int WORD_W = RATIO * SER_W;
  localparam int BUS_W  = NLANES * WORD_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FC_W   = PTR_W + 1;
  localparam int CNT_W  = $clog2(RATIO);

  localparam logic [0:0] ST_OFF     = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;
  localparam logic [1:0] MODE_DATA  = 2'd0;
  localparam logic [1:0] MODE_PRBS  = 2'd1;
  localparam logic [1:0] MODE_CLOCK = 2'd2;

  function automatic logic [WORD_W-1:0] bit_rev(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) r[i] = w[WORD_W-1-i];
    return r;
  endfunction

  // x^7+x^6+1 advanced SER_W steps; returns {chunk, next_state}, chunk LSB is the earliest bit.
  function automatic logic [SER_W+6:0] prbs_adv(input logic [6:0] seed);
    logic [6:0]       s;
    logic [SER_W-1:0] c;
    s = seed;
    c = '0;
    for (int i = 0; i < SER_W; i++) begin
      c[i] = s[6] ^ s[5];
      s    = {s[5:0], s[6] ^ s[5]};
    end
    return {c, s};
  endfunction

  function automatic logic [7*NLANES-1:0] prbs_seeds();
    logic [7*NLANES-1:0] s;
    for (int l = 0; l < NLANES; l++) s[l*7 +: 7] = 7'h7F ^ 7'(l);
    return s;
  endfunction

  logic [0:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              mode_q, mode_d;
  logic                    have_q, have_d;
  logic [BUS_W-1:0]        sr_q, sr_d;
  logic [7*NLANES-1:0]     lfsr_q, lfsr_d;
  logic [BUS_W-1:0]        mem_q [FIFO_DEPTH];
  logic [BUS_W-1:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]         fcnt_q, fcnt_d;
  logic                    in_ready_q, in_ready_d;
  logic [NLANES*SER_W-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    underflow_q, underflow_d;

  logic                    push_s, pop_s, boundary_s, uf_set_s;
  logic [1:0]              eff_mode_s;
  logic [BUS_W-1:0]        head_s, cur_s;
  logic [SER_W+6:0]        adv_s;

  // Next-state logic: OFF/RUN sequencing, word slicing, pattern generation and FIFO bookkeeping.
  always_comb begin
    push_s      = in_if.in_valid && in_ready_q;
    boundary_s  = (state_q == ST_RUN) && (cnt_q == '0);
    eff_mode_s  = boundary_s ? mode : mode_q;
    head_s      = mem_q[rd_ptr_q];
    pop_s       = 1'b0;
    uf_set_s    = 1'b0;
    cur_s       = '0;
    adv_s       = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    have_d      = have_q;
    sr_d        = sr_q;
    lfsr_d      = lfsr_q;
    out_data_d  = '0;
    out_valid_d = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (ser_en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_RUN: begin
        cnt_d  = cnt_q + CNT_W'(1);
        mode_d = eff_mode_s;
        if ((cnt_q == CNT_W'(RATIO-1)) && !ser_en) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_RUN;
        end
        case (eff_mode_s)
          MODE_DATA: begin
            if (boundary_s) begin
              if (fcnt_q != '0) begin
                pop_s  = 1'b1;
                have_d = 1'b1;
                for (int l = 0; l < NLANES; l++) begin
                  cur_s[l*WORD_W +: WORD_W] = msb_first ? bit_rev(head_s[l*WORD_W +: WORD_W])
                                                        : head_s[l*WORD_W +: WORD_W];
                end
              end else begin
                have_d   = 1'b0;
                uf_set_s = 1'b1;
              end
            end else begin
              cur_s = sr_q;
            end
            // Slice 0 leaves straight from the loaded word; the remainder shifts down each clk.
            for (int l = 0; l < NLANES; l++) begin
              sr_d[l*WORD_W +: WORD_W] = cur_s[l*WORD_W +: WORD_W] >> SER_W;
              if (have_d) begin
                out_data_d[l*SER_W +: SER_W] = cur_s[l*WORD_W +: SER_W];
              end else begin
                out_data_d[l*SER_W +: SER_W] = '0;
              end
            end
            out_valid_d = have_d;
          end
          MODE_PRBS: begin
            have_d = 1'b0;
            for (int l = 0; l < NLANES; l++) begin
              adv_s                        = prbs_adv(lfsr_q[l*7 +: 7]);
              out_data_d[l*SER_W +: SER_W] = adv_s[SER_W+6:7];
              lfsr_d[l*7 +: 7]             = adv_s[6:0];
            end
          end
          MODE_CLOCK: begin
            have_d     = 1'b0;
            out_data_d = {(NLANES*SER_W/2){2'b10}};
          end
          default: begin
            have_d     = 1'b0;
            out_data_d = '0;
          end
        endcase
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    if (uf_set_s) begin
      underflow_d = 1'b1;
    end else if (underflow_clr) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end

    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_if.in_data;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_s);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_s);
    fcnt_d     = fcnt_q + FC_W'(push_s) - FC_W'(pop_s);
    in_ready_d = (fcnt_d < FC_W'(FIFO_DEPTH));
  end

  // Control, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      mode_q      <= MODE_DATA;
      have_q      <= 1'b0;
      sr_q        <= '0;
      lfsr_q      <= prbs_seeds();
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      have_q      <= have_d;
      sr_q        <= sr_d;
      lfsr_q      <= lfsr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underflow_q <= underflow_d;
    end
  end

  // FIFO storage; emptiness is governed by the reset pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign in_if.in_ready = in_ready_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign underflow      = underflow_q;
endmodule

// File: tb/tb_tx_lane_gearbox.sv
// Randomised bench for tx_lane_gearbox: a queue-based model of the FIFO and output stream,
// with PRBS7 expectations generated from the polynomial recurrence.
module tb_tx_lane_gearbox;
  localparam int NLANES     = 4;
  localparam int SER_W      = 4;
  localparam int RATIO      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int WORD_W     = RATIO * SER_W;
  localparam int BUS_W      = NLANES * WORD_W;
  localparam int OUT_W      = NLANES * SER_W;
  localparam int PRBS_LEN   = 8192;

  logic             clk = 1'b0;
  logic             rstb;
  logic [1:0]       mode;
  logic             msb_first;
  logic             ser_en;
  logic             underflow_clr;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             underflow;

  tx_lane_gearbox_if #(.W(BUS_W)) in_if ();

  tx_lane_gearbox #(
    .NLANES(NLANES), .SER_W(SER_W), .RATIO(RATIO), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstb(rstb), .in_if(in_if), .mode(mode), .msb_first(msb_first),
    .ser_en(ser_en), .out_data(out_data), .out_valid(out_valid),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BUS_W-1:0] tx_q[$];
  logic [BUS_W-1:0] m_fifo[$];
  bit               m_running;
  int               m_pos;
  logic [1:0]       m_mode;
  bit               m_have;
  logic [BUS_W-1:0] m_word;
  bit               m_uf;
  bit               m_ready;
  logic [OUT_W-1:0] m_out;
  bit               m_valid;
  int               m_pidx;
  bit               prbs_h[PRBS_LEN+7];
  bit               prbs_seq[NLANES][PRBS_LEN];
  bit               reached;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit n of the lane stream obeys x(n) = x(n-7) ^ x(n-6); the seed supplies the 7 preceding bits.
  task automatic build_prbs();
    logic [6:0] seed;
    for (int l = 0; l < NLANES; l++) begin
      seed = 7'h7F ^ 7'(l);
      for (int i = 0; i < 7; i++) prbs_h[i] = seed[6-i];
      for (int n = 7; n < PRBS_LEN + 7; n++) prbs_h[n] = prbs_h[n-7] ^ prbs_h[n-6];
      for (int n = 0; n < PRBS_LEN; n++) prbs_seq[l][n] = prbs_h[n+7];
    end
  endtask

  function automatic logic [BUS_W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [BUS_W-1:0] ramp_word(input int w);
    logic [BUS_W-1:0] r;
    int               base;
    base = int'($urandom_range(0, 255));
    for (int l = 0; l < NLANES; l++)
      for (int k = 0; k < RATIO; k++)
        r[l*WORD_W + k*SER_W +: SER_W] = SER_W'(base + w + l*RATIO + k);
    return r;
  endfunction

  // Predicts what the coming clock edge does, given the inputs currently applied.
  task automatic model_edge();
    bit               push;
    bit               uf_set;
    bit               stop;
    logic [WORD_W-1:0] lw;
    logic [BUS_W-1:0]  w;
    if (!rstb) begin
      m_fifo.delete();
      m_running = 1'b0; m_pos = 0; m_have = 1'b0; m_uf = 1'b0; m_ready = 1'b0;
      m_out = '0; m_valid = 1'b0; m_pidx = 0; m_mode = 2'd0;
      return;
    end
    push   = in_if.in_valid && m_ready;
    uf_set = 1'b0;
    m_out  = '0;
    m_valid = 1'b0;
    if (!m_running) begin
      if (ser_en) begin
        m_running = 1'b1;
        m_pos     = 0;
      end
    end else begin
      if (m_pos == 0) begin
        m_mode = mode;
        m_have = 1'b0;
        if (mode == 2'd0) begin
          if (m_fifo.size() > 0) begin
            w = m_fifo.pop_front();
            if (msb_first) begin
              for (int l = 0; l < NLANES; l++) begin
                lw = w[l*WORD_W +: WORD_W];
                for (int j = 0; j < WORD_W; j++) w[l*WORD_W + j] = lw[WORD_W-1-j];
              end
            end
            m_word = w;
            m_have = 1'b1;
          end else begin
            uf_set = 1'b1;
          end
        end
      end
      for (int l = 0; l < NLANES; l++) begin
        lw = m_word[l*WORD_W +: WORD_W];
        for (int b = 0; b < SER_W; b++) begin
          case (m_mode)
            2'd0:    m_out[l*SER_W + b] = m_have ? lw[m_pos*SER_W + b] : 1'b0;
            2'd1:    m_out[l*SER_W + b] = prbs_seq[l][(m_pidx + b) % PRBS_LEN];
            2'd2:    m_out[l*SER_W + b] = (b % 2 == 1);
            default: m_out[l*SER_W + b] = 1'b0;
          endcase
        end
      end
      m_valid = (m_mode == 2'd0) && m_have;
      if (m_mode == 2'd1) m_pidx += SER_W;
      stop  = (m_pos == RATIO - 1) && !ser_en;
      m_pos = (m_pos + 1) % RATIO;
      if (stop) m_running = 1'b0;
    end
    if (uf_set) m_uf = 1'b1;
    else if (underflow_clr) m_uf = 1'b0;
    if (push) begin
      m_fifo.push_back(in_if.in_data);
      void'(tx_q.pop_front());
    end
    m_ready = (m_fifo.size() < FIFO_DEPTH);
  endtask

  task automatic tick();
    in_if.in_valid = (tx_q.size() > 0);
    in_if.in_data  = (tx_q.size() > 0) ? tx_q[0] : '0;
    model_edge();
    @(posedge clk);
    #1;
    check_eq("out_data",  64'(out_data),       64'(m_out));
    check_eq("out_valid", 64'(out_valid),      64'(m_valid));
    check_eq("underflow", 64'(underflow),      64'(m_uf));
    check_eq("in_ready",  64'(in_if.in_ready), 64'(m_ready));
  endtask

  initial begin
    rstb = 1'b0; mode = 2'd0; msb_first = 1'b0; ser_en = 1'b0; underflow_clr = 1'b0;
    build_prbs();
    tick(); tick();
    rstb = 1'b1;
    tick();

    // DATA, LSB first, four lane-distinct ramps back to back
    ser_en = 1'b1;
    for (int w = 0; w < 4; w++) tx_q.push_back(ramp_word(w));
    repeat (4*RATIO + 3) tick();
    underflow_clr = 1'b1; tick(); underflow_clr = 1'b0;

    // msb_first raised mid-word and dropped later; only boundary values count
    for (int w = 0; w < 4; w++) tx_q.push_back(rand_word());
    repeat (6) tick();
    msb_first = 1'b1; repeat (RATIO) tick();
    msb_first = 1'b0; repeat (3*RATIO) tick();

    // fill the FIFO while stopped, hold one extra word, then drain in order
    ser_en = 1'b0; repeat (2*RATIO) tick();
    for (int w = 0; w < FIFO_DEPTH + 1; w++) tx_q.push_back(rand_word());
    repeat (8) tick();
    ser_en = 1'b1; repeat (8*RATIO) tick();

    // starved run with random clear pulses, some landing on a boundary
    repeat (6*RATIO) begin
      underflow_clr = ($urandom_range(0, 2) == 0);
      tick();
    end
    underflow_clr = 1'b0;

    // pattern modes
    mode = 2'd1; repeat (127*7) tick();
    mode = 2'd2; repeat (3*RATIO) tick();
    mode = 2'd3; repeat (2*RATIO) tick();

    // reset in the middle of a data word
    mode = 2'd0;
    tx_q.push_back(rand_word()); tx_q.push_back(rand_word());
    reached = 1'b0;
    for (int i = 0; i < 4*RATIO && !reached; i++) begin
      tick();
      reached = m_running && (m_pos == 2);
    end
    check_eq("cnt2_reached", 64'(reached), 64'(1));
    tx_q.delete();
    rstb = 1'b0; tick();
    rstb = 1'b1; tick();
    repeat (RATIO) tick();
    tx_q.push_back(rand_word());
    repeat (3*RATIO) tick();

    // random soak
    repeat (400) begin
      mode          = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      msb_first     = ($urandom_range(0, 1) == 1);
      ser_en        = ($urandom_range(0, 7) != 0);
      underflow_clr = ($urandom_range(0, 7) == 0);
      if (tx_q.size() < 2 && $urandom_range(0, 1) == 1) tx_q.push_back(rand_word());
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
